// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite master bus bundle used between the fetch/data arbiter and the external slave.
interface axi_lite_arbiter_if;
  logic [31:0] ARaddr;
  logic        ARvalid;
  logic [2:0]  ARprot;
  logic        ARready;
  logic [31:0] Rdata;
  logic        Rvalid;
  logic        Rready;
  logic [31:0] AWaddr;
  logic        AWvalid;
  logic [2:0]  AWprot;
  logic        AWready;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Wvalid;
  logic        Wready;
  logic        Bvalid;
  logic        Bready;

  modport master (
    output ARaddr, ARvalid, ARprot, input ARready,
    input  Rdata, Rvalid, output Rready,
    output AWaddr, AWvalid, AWprot, input AWready,
    output Wdata, Wstrb, Wvalid, input Wready,
    input  Bvalid, output Bready
  );

  modport slave (
    input  ARaddr, ARvalid, ARprot, output ARready,
    output Rdata, Rvalid, input Rready,
    input  AWaddr, AWvalid, AWprot, output AWready,
    input  Wdata, Wstrb, Wvalid, output Wready,
    output Bvalid, input Bready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between instruction fetch
// and data load/store, with a watchdog that aborts stalled transactions.
module axi_lite_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic [31:0] f_rdata,
  output logic        f_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  axi_lite_arbiter_if.master axi
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        own_q, own_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  arprot_q, arprot_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
  logic        f_done_q, f_done_d, d_done_q, d_done_d, err_q, err_d;
  logic [31:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        grant_data, timeout, aw_hs, w_hs;

  assign aw_hs   = awvalid_q & axi.AWready;
  assign w_hs    = wvalid_q & axi.Wready;
  assign timeout = (state_q != IDLE) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    own_d      = own_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    arprot_d   = arprot_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    aw_ok_d    = aw_ok_q;
    w_ok_d     = w_ok_q;
    f_done_d   = 1'b0;
    d_done_d   = 1'b0;
    err_d      = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    cnt_d      = (state_q != IDLE) ? cnt_q + 16'd1 : cnt_q;
    grant_data = d_req && (!f_req || !last_q);

    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          own_d   = grant_data;
          last_d  = grant_data;
          cnt_d   = '0;
          addr_d  = grant_data ? d_addr : f_addr;
          wdata_d = d_wdata;
          wstrb_d = d_wstrb;
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          if (grant_data && d_we) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            arprot_d  = grant_data ? 3'b000 : 3'b100;
          end
        end
      end
      RD_ADDR: begin
        if (axi.ARready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.Rvalid) begin
          rready_d = 1'b0;
          state_d  = IDLE;
          if (own_q) begin
            d_rdata_d = axi.Rdata;
            d_done_d  = 1'b1;
          end else begin
            f_rdata_d = axi.Rdata;
            f_done_d  = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W complete independently; the flags remember an earlier handshake
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_ok_d   = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_ok_d   = 1'b1;
        end
        if ((aw_ok_q || aw_hs) && (w_ok_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi.Bvalid) begin
          bready_d = 1'b0;
          d_done_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog overrides any handshake completing in the same cycle
    if (timeout) begin
      state_d   = IDLE;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      aw_ok_d   = 1'b0;
      w_ok_d    = 1'b0;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
      f_done_d  = !own_q;
      d_done_d  = own_q;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      own_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arprot_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arprot_q  <= arprot_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
      f_done_q  <= f_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign f_rdata     = f_rdata_q;
  assign f_done      = f_done_q;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign err         = err_q;
  assign axi.ARaddr  = addr_q;
  assign axi.ARvalid = arvalid_q;
  assign axi.ARprot  = arprot_q;
  assign axi.Rready  = rready_q;
  assign axi.AWaddr  = addr_q;
  assign axi.AWvalid = awvalid_q;
  assign axi.AWprot  = '0;
  assign axi.Wdata   = wdata_q;
  assign axi.Wstrb   = wstrb_q;
  assign axi.Wvalid  = wvalid_q;
  assign axi.Bready  = bready_q;
endmodule
